// File: rtl/dehaze_pkg.sv
// dehaze_pkg: shared defaults for the dehazing datapath (frame geometry, UART
// frame header bytes) and the frame loader state encoding. vga_pic reads the
// same PIC_W/PIC_H defaults so both ends agree on the buffer layout.
package dehaze_pkg;

  localparam int PIC_W_DEF       = 100;
  localparam int PIC_H_DEF       = 100;
  localparam int ADDR_W_DEF      = 14;
  localparam int TIMEOUT_CYC_DEF = 5_000_000;   // 100 ms at 50 MHz

  localparam logic [7:0] SYNC0_DEF = 8'hA5;
  localparam logic [7:0] SYNC1_DEF = 8'h5A;

  // Loader state encoding; CHECK is only reachable in checksum builds.
  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_SYNC      = 3'd1;
  localparam logic [STATE_W-1:0] ST_LOAD      = 3'd2;
  localparam logic [STATE_W-1:0] ST_CHECK     = 3'd3;
  localparam logic [STATE_W-1:0] ST_WAIT_SWAP = 3'd4;

  // Number of pixels in one frame.
  function automatic int frame_pixels(input int w, input int h);
    return w * h;
  endfunction

  // States in which a stalled byte stream must be caught by the watchdog.
  function automatic logic watchdog_active(input logic [STATE_W-1:0] st);
    return (st == ST_SYNC) || (st == ST_LOAD) || (st == ST_CHECK);
  endfunction

endpackage

// File: rtl/dehaze_frame_loader_rx_watchdog.sv
// rx_watchdog: counts idle cycles while enabled. The count restarts on clr or
// whenever the watchdog is disabled. timeout is high for one cycle when the
// count reaches TIMEOUT_CYC-1 without an intervening clear.
module rx_watchdog
  import dehaze_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic en,
  input  logic clr,
  output logic timeout
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // Idle-cycle counter; wraps to zero on expiry so it cannot fire twice in a row.
  always_ff @(posedge sys_clk) begin
    // NOTE: reset is synchronous, so it is tested inside the clocked block and
    // the sensitivity list holds only the clock edge.
    if (sys_rst) begin
      cnt <= '0;
    end else if (!en || clr) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign timeout = en && !clr && (cnt == CNT_LAST);

endmodule

// File: rtl/dehaze_frame_loader.sv
// dehaze_frame_loader: hunts the SYNC0/SYNC1 header in the UART byte stream,
// writes one frame of RGB332 pixels into the back bank of a ping-pong frame
// RAM, and swaps banks only on a display frame start so the reader never sees
// a partial frame. A watchdog aborts frames whose byte stream stalls.
//
// Build option: define DEHAZE_LOADER_CKSUM_EN to require an XOR trailer byte
// after the pixels (adds the CHECK state and the err_cksum output).
module dehaze_frame_loader
  import dehaze_pkg::*;
#(
  parameter int         PIC_W       = PIC_W_DEF,
  parameter int         PIC_H       = PIC_H_DEF,
  parameter int         ADDR_W      = ADDR_W_DEF,
  parameter logic [7:0] SYNC0       = SYNC0_DEF,
  parameter logic [7:0] SYNC1       = SYNC1_DEF,
  parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              disp_frame_start,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic              frame_done,
  output logic              err_timeout,
`ifdef DEHAZE_LOADER_CKSUM_EN
  output logic              err_cksum,
`endif
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(frame_pixels(PIC_W, PIC_H) - 1);

  logic [STATE_W-1:0] state;
  logic [ADDR_W-1:0]  pix_cnt;
  logic               wd_timeout;

  // Watchdog runs only while a frame is being received; any byte restarts it.
  rx_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx_watchdog (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .en      (watchdog_active(state)),
    .clr     (rx_valid),
    .timeout (wd_timeout)
  );

  assign busy = (state != ST_IDLE);

`ifdef DEHAZE_LOADER_CKSUM_EN
  logic [7:0] cksum;

  // Running XOR of the pixel bytes of the frame in progress.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cksum <= '0;
    end else if (state == ST_SYNC && rx_valid && rx_data == SYNC1) begin
      cksum <= '0;
    end else if (state == ST_LOAD && rx_valid) begin
      cksum <= cksum ^ rx_data;
    end
  end
`endif

  // Loader FSM with registered write port, bank pointers and event pulses.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= ST_IDLE;
      pix_cnt     <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      wr_bank     <= 1'b1;
      rd_bank     <= 1'b0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
`ifdef DEHAZE_LOADER_CKSUM_EN
      err_cksum   <= 1'b0;
`endif
    end else begin
      // NOTE: state is updated with non-blocking assignments so every branch
      // below sees the values from before this clock edge.
      wr_en       <= 1'b0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
`ifdef DEHAZE_LOADER_CKSUM_EN
      err_cksum   <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (rx_valid && rx_data == SYNC0) begin
            state <= ST_SYNC;
          end
        end

        ST_SYNC: begin
          if (wd_timeout) begin
            err_timeout <= 1'b1;
            state       <= ST_IDLE;
          end else if (rx_valid) begin
            if (rx_data == SYNC1) begin
              pix_cnt <= '0;
              state   <= ST_LOAD;
            end else if (rx_data != SYNC0) begin
              state <= ST_IDLE;
            end
          end
        end

        ST_LOAD: begin
          if (wd_timeout) begin
            err_timeout <= 1'b1;
            state       <= ST_IDLE;
          end else if (rx_valid) begin
            wr_en   <= 1'b1;
            wr_addr <= pix_cnt;
            wr_data <= rx_data;
            pix_cnt <= pix_cnt + ADDR_W'(1);
            if (pix_cnt == LAST_PIX) begin
`ifdef DEHAZE_LOADER_CKSUM_EN
              state      <= ST_CHECK;
`else
              frame_done <= 1'b1;
              state      <= ST_WAIT_SWAP;
`endif
            end
          end
        end

`ifdef DEHAZE_LOADER_CKSUM_EN
        ST_CHECK: begin
          if (wd_timeout) begin
            err_timeout <= 1'b1;
            state       <= ST_IDLE;
          end else if (rx_valid) begin
            if (rx_data == cksum) begin
              frame_done <= 1'b1;
              state      <= ST_WAIT_SWAP;
            end else begin
              err_cksum <= 1'b1;
              state     <= ST_IDLE;
            end
          end
        end
`endif

        ST_WAIT_SWAP: begin
          // Bytes arriving here are dropped until the display takes the frame.
          if (disp_frame_start) begin
            rd_bank <= wr_bank;
            wr_bank <= ~wr_bank;
            state   <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dehaze_frame_loader.sv
// Bench for dehaze_frame_loader with a 4x2 frame and a 100-cycle watchdog.
// Expected RAM writes are queued as bytes are sent and matched against wr_en
// cycles by a monitor; scenario tasks check banks, busy and event pulses.
// Define DEHAZE_LOADER_CKSUM_EN to exercise the trailer checksum build.
`timescale 1ns/1ps
module tb_dehaze_frame_loader;

  localparam int NPIX   = 8;
  localparam int ADDR_W = 14;
`ifdef DEHAZE_LOADER_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    logic              bank;
    logic              fd;
  } exp_t;

  logic              clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              disp_frame_start = 1'b0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_bank;
  logic              rd_bank;
  logic              frame_done;
  logic              err_timeout;
  logic              busy;
`ifdef DEHAZE_LOADER_CKSUM_EN
  logic              err_cksum;
`endif

  int   total = 0;
  int   bad = 0;
  int   fd_cnt = 0;
  int   to_cnt = 0;
  int   ck_cnt = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic exp_wr_bank = 1'b1;

  localparam logic [27:0] RST_VEC = {1'b0, 14'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  always #10 clk = ~clk;

  dehaze_frame_loader #(
    .PIC_W       (4),
    .PIC_H       (2),
    .ADDR_W      (ADDR_W),
    .SYNC0       (8'hA5),
    .SYNC1       (8'h5A),
    .TIMEOUT_CYC (100)
  ) dut (
    .sys_clk          (clk),
    .sys_rst          (sys_rst),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .disp_frame_start (disp_frame_start),
    .wr_en            (wr_en),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .wr_bank          (wr_bank),
    .rd_bank          (rd_bank),
    .frame_done       (frame_done),
    .err_timeout      (err_timeout),
`ifdef DEHAZE_LOADER_CKSUM_EN
    .err_cksum        (err_cksum),
`endif
    .busy             (busy)
  );

  // Monitor: scoreboard match of every write, plus pulse counters.
  always @(negedge clk) begin
    if (frame_done)  fd_cnt++;
    if (err_timeout) to_cnt++;
`ifdef DEHAZE_LOADER_CKSUM_EN
    if (err_cksum)   ck_cnt++;
`endif
    if (wr_en) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got addr=%0d data=%h bank=%0d exp no write",
                 wr_addr, wr_data, wr_bank);
      end else begin
        mon_e = exp_q.pop_front();
        if ({wr_addr, wr_data, wr_bank, frame_done} !== mon_e) begin
          bad++;
          $display("FAIL write got addr=%0d data=%h bank=%0d fd=%0d exp addr=%0d data=%h bank=%0d fd=%0d",
                   wr_addr, wr_data, wr_bank, frame_done,
                   mon_e.addr, mon_e.data, mon_e.bank, mon_e.fd);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL global_timeout got time=%0t exp finish earlier", $time);
    $fatal(1, "bench time limit");
  end

  function automatic logic [27:0] out_vec();
    return {wr_en, wr_addr, wr_data, wr_bank, rd_bank, frame_done, err_timeout, busy};
  endfunction

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dfs);
    @(negedge clk);
    rx_data          = b;
    rx_valid         = 1'b1;
    disp_frame_start = dfs;
    @(negedge clk);
    rx_valid         = 1'b0;
    disp_frame_start = 1'b0;
  endtask

  task automatic pulse_dfs();
    @(negedge clk);
    disp_frame_start = 1'b1;
    @(negedge clk);
    disp_frame_start = 1'b0;
  endtask

  // Header plus NPIX pixels base..base+7; queues the expected writes.
  task automatic send_pixels(input logic [7:0] base, input logic dfs_last, output logic [7:0] x);
    exp_t e;
    logic [7:0] b;
    x = '0;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b0);
    for (int i = 0; i < NPIX; i++) begin
      b      = base + 8'(i);
      e.addr = ADDR_W'(i);
      e.data = b;
      e.bank = exp_wr_bank;
      e.fd   = !CK && (i == NPIX - 1);
      exp_q.push_back(e);
      x = x ^ b;
      send_byte(b, dfs_last && (i == NPIX - 1));
    end
  endtask

  // Complete valid frame; in checksum builds the trailer carries dfs_last.
  task automatic send_frame(input logic [7:0] base, input logic dfs_last);
    logic [7:0] x;
    send_pixels(base, dfs_last && !CK, x);
`ifdef DEHAZE_LOADER_CKSUM_EN
    send_byte(x, dfs_last);
`endif
  endtask

  task automatic check_banks(input string name, input logic exp_busy);
    total++;
    if ({wr_bank, rd_bank, busy} !== {exp_wr_bank, ~exp_wr_bank, exp_busy}) begin
      bad++;
      $display("FAIL %s got wr_bank=%0d rd_bank=%0d busy=%0d exp wr_bank=%0d rd_bank=%0d busy=%0d",
               name, wr_bank, rd_bank, busy, exp_wr_bank, ~exp_wr_bank, exp_busy);
    end
  endtask

  task automatic check_drained(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s got pending=%0d exp pending=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (out_vec() !== RST_VEC) begin
      bad++;
      $display("FAIL reset_values got %b exp %b", out_vec(), RST_VEC);
    end
    @(negedge clk);
    sys_rst = 1'b0;
  endtask

  task automatic test_basic_frame();
    int fd0 = fd_cnt;
    send_frame(8'h01, 1'b0);
    settle();
    total++;
    if (fd_cnt - fd0 !== 1) begin
      bad++;
      $display("FAIL basic_frame_done got=%0d exp=1", fd_cnt - fd0);
    end
    check_banks("basic_wait_swap", 1'b1);
    repeat (5) @(negedge clk);
    settle();
    check_banks("basic_hold_before_dfs", 1'b1);
    pulse_dfs();
    exp_wr_bank = ~exp_wr_bank;
    settle();
    check_banks("basic_after_swap", 1'b0);
    check_drained("basic_drained");
  endtask

  task automatic test_header_hunt();
    send_byte(8'h11, 1'b0);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'hA5, 1'b0);
    settle();
    check_drained("hunt_no_early_write");
    send_frame(8'h41, 1'b0);
    pulse_dfs();
    exp_wr_bank = ~exp_wr_bank;
    settle();
    check_banks("hunt_after_swap", 1'b0);
    check_drained("hunt_drained");
  endtask

  task automatic test_timeout();
    exp_t e;
    int   to0 = to_cnt;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b0);
    for (int i = 0; i < 3; i++) begin
      e.addr = ADDR_W'(i);
      e.data = 8'(i + 1);
      e.bank = exp_wr_bank;
      e.fd   = 1'b0;
      exp_q.push_back(e);
      send_byte(8'(i + 1), 1'b0);
    end
    repeat (95) @(negedge clk);
    total++;
    if (to_cnt - to0 !== 0) begin
      bad++;
      $display("FAIL timeout_early got=%0d exp=0", to_cnt - to0);
    end
    repeat (15) @(negedge clk);
    settle();
    total++;
    if (to_cnt - to0 !== 1) begin
      bad++;
      $display("FAIL timeout_pulse got=%0d exp=1", to_cnt - to0);
    end
    check_banks("timeout_banks", 1'b0);
    check_drained("timeout_partial");
    send_frame(8'h10, 1'b0);
    pulse_dfs();
    exp_wr_bank = ~exp_wr_bank;
    settle();
    check_banks("timeout_restart_swap", 1'b0);
    check_drained("timeout_drained");
  endtask

  task automatic test_dfs_collision();
    int fd0;
    pulse_dfs();
    settle();
    check_banks("dfs_in_idle_ignored", 1'b0);
    fd0 = fd_cnt;
    send_frame(8'h80, 1'b1);
    settle();
    check_banks("dfs_same_cycle_no_swap", 1'b1);
    send_byte(8'hC3, 1'b0);
    send_byte(8'h3C, 1'b0);
    settle();
    check_drained("wait_swap_drops_bytes");
    total++;
    if (fd_cnt - fd0 !== 1) begin
      bad++;
      $display("FAIL collision_frame_done got=%0d exp=1", fd_cnt - fd0);
    end
    pulse_dfs();
    exp_wr_bank = ~exp_wr_bank;
    settle();
    check_banks("collision_later_swap", 1'b0);
  endtask

  task automatic test_mid_frame_reset();
    exp_t e;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b0);
    for (int i = 0; i < 4; i++) begin
      e.addr = ADDR_W'(i);
      e.data = 8'hE0 + 8'(i);
      e.bank = exp_wr_bank;
      e.fd   = 1'b0;
      exp_q.push_back(e);
      send_byte(8'hE0 + 8'(i), 1'b0);
    end
    @(negedge clk);
    sys_rst = 1'b1;
    settle();
    total++;
    if (out_vec() !== RST_VEC) begin
      bad++;
      $display("FAIL mid_frame_reset got %b exp %b", out_vec(), RST_VEC);
    end
    @(negedge clk);
    sys_rst = 1'b0;
    exp_wr_bank = 1'b1;
    check_drained("reset_drained");
  endtask

`ifdef DEHAZE_LOADER_CKSUM_EN
  task automatic test_checksum();
    logic [7:0] x;
    int fd0 = fd_cnt;
    int ck0 = ck_cnt;
    send_pixels(8'h01, 1'b0, x);
    total++;
    if (x !== 8'h08) begin
      bad++;
      $display("FAIL cksum_model got=%h exp=08", x);
    end
    send_byte(x, 1'b0);
    settle();
    total++;
    if ({fd_cnt - fd0, ck_cnt - ck0} !== {32'd1, 32'd0}) begin
      bad++;
      $display("FAIL cksum_match got fd=%0d ck=%0d exp fd=1 ck=0", fd_cnt - fd0, ck_cnt - ck0);
    end
    pulse_dfs();
    exp_wr_bank = ~exp_wr_bank;
    settle();
    check_banks("cksum_match_swap", 1'b0);
    fd0 = fd_cnt;
    send_pixels(8'h01, 1'b0, x);
    send_byte(8'h00, 1'b0);
    settle();
    total++;
    if ({fd_cnt - fd0, ck_cnt - ck0} !== {32'd0, 32'd1}) begin
      bad++;
      $display("FAIL cksum_mismatch got fd=%0d ck=%0d exp fd=0 ck=1", fd_cnt - fd0, ck_cnt - ck0);
    end
    check_banks("cksum_mismatch_idle", 1'b0);
    pulse_dfs();
    settle();
    check_banks("cksum_mismatch_no_swap", 1'b0);
    check_drained("cksum_drained");
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_header_hunt();
    test_timeout();
    test_dfs_collision();
    test_mid_frame_reset();
`ifdef DEHAZE_LOADER_CKSUM_EN
    test_checksum();
`endif
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
